// File: rtl/sc_collatz_pkg.sv
// rtl/sc_collatz_pkg.sv - shared state/errcode encodings and default widths for the Collatz stepper
package sc_collatz_pkg;

    localparam int DEF_DATAWIDTH_BUS = 8;
    localparam int DEF_STEPWIDTH     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10,
        ERR  = 2'b11
    } collatzState_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_ZERO  = 2'b01,
        ERR_OVF   = 2'b10,
        ERR_STEPS = 2'b11
    } collatzErr_t;

endpackage

// File: rtl/sc_collatz_stepper_if.sv
// rtl/sc_collatz_stepper_if.sv - seed/start and status bundle for the Collatz stepper; COLLATZ_MAXTRACK_EN adds peak_OutBUS
interface sc_collatz_stepper_if #(
    parameter int DATAWIDTH_BUS = 8,
    parameter int STEPWIDTH     = 8
);
    logic [DATAWIDTH_BUS-1:0] seed_InBUS;
    logic                     start_In;
    logic [DATAWIDTH_BUS-1:0] value_OutBUS;
    logic [STEPWIDTH-1:0]     steps_OutBUS;
    logic                     busy_Out;
    logic                     done_Out;
    logic                     err_Out;
    logic [1:0]               errcode_OutBUS;
`ifdef COLLATZ_MAXTRACK_EN
    logic [DATAWIDTH_BUS-1:0] peak_OutBUS;
`endif

    modport master (
        output seed_InBUS,
        output start_In,
        input  value_OutBUS,
        input  steps_OutBUS,
        input  busy_Out,
        input  done_Out,
        input  err_Out,
        input  errcode_OutBUS
`ifdef COLLATZ_MAXTRACK_EN
        , input peak_OutBUS
`endif
    );

    modport slave (
        input  seed_InBUS,
        input  start_In,
        output value_OutBUS,
        output steps_OutBUS,
        output busy_Out,
        output done_Out,
        output err_Out,
        output errcode_OutBUS
`ifdef COLLATZ_MAXTRACK_EN
        , output peak_OutBUS
`endif
    );

endinterface

// File: rtl/sc_collatz_alu.sv
// rtl/sc_collatz_alu.sv - one combinational Collatz step with overflow detect on the 3n+1 path
module sc_collatz_alu #(
    parameter int DATAWIDTH_BUS = 8
) (
    input  logic [DATAWIDTH_BUS-1:0] value,
    output logic [DATAWIDTH_BUS-1:0] nextValue,
    output logic                     overflow
);
    logic [DATAWIDTH_BUS+1:0] wideValue;
    logic [DATAWIDTH_BUS+1:0] tripled;

    // Two guard bits hold 3n+1 for any n, so overflow is just the top bits.
    always_comb begin
        wideValue = {2'b00, value};
        tripled   = (wideValue << 1) + wideValue + (DATAWIDTH_BUS+2)'(1);
        if (value[0]) begin
            nextValue = tripled[DATAWIDTH_BUS-1:0];
            overflow  = |tripled[DATAWIDTH_BUS+1:DATAWIDTH_BUS];
        end else begin
            nextValue = value >> 1;
            overflow  = 1'b0;
        end
    end

endmodule

// File: rtl/sc_collatz_stepper.sv
// rtl/sc_collatz_stepper.sv - iterative Collatz engine fed by the fixed seed register; COLLATZ_MAXTRACK_EN adds peak tracking
module sc_collatz_stepper
    import sc_collatz_pkg::*;
#(
    parameter int DATAWIDTH_BUS = DEF_DATAWIDTH_BUS,
    parameter int STEPWIDTH     = DEF_STEPWIDTH
) (
    input  logic                 SC_RegFIXED_CLOCK_50,
    input  logic                 SC_RegFIXED_RESET_InHigh,
    sc_collatz_stepper_if.slave  collatzBus
);
    localparam logic [STEPWIDTH-1:0] STEPS_MAX = '1;

    collatzState_t            state, stateNext;
    collatzErr_t              errcode, errcodeNext;
    logic [DATAWIDTH_BUS-1:0] value, valueNext, aluValue;
    logic [STEPWIDTH-1:0]     steps, stepsNext;
    logic                     aluOverflow;
`ifdef COLLATZ_MAXTRACK_EN
    logic [DATAWIDTH_BUS-1:0] peak, peakNext;
`endif

    sc_collatz_alu #(.DATAWIDTH_BUS(DATAWIDTH_BUS)) alu (
        .value     (value),
        .nextValue (aluValue),
        .overflow  (aluOverflow)
    );

    always_ff @(posedge SC_RegFIXED_CLOCK_50 or posedge SC_RegFIXED_RESET_InHigh) begin
        if (SC_RegFIXED_RESET_InHigh) begin
            state   <= IDLE;
            errcode <= ERR_NONE;
            value   <= '0;
            steps   <= '0;
`ifdef COLLATZ_MAXTRACK_EN
            peak    <= '0;
`endif
        end else begin
            state   <= stateNext;
            errcode <= errcodeNext;
            value   <= valueNext;
            steps   <= stepsNext;
`ifdef COLLATZ_MAXTRACK_EN
            peak    <= peakNext;
`endif
        end
    end

    always_comb begin
        stateNext   = state;
        errcodeNext = errcode;
        valueNext   = value;
        stepsNext   = steps;
`ifdef COLLATZ_MAXTRACK_EN
        peakNext    = peak;
`endif
        case (state)
            RUN: begin
                // Checks are ordered: zero, reached one, step budget, then the step itself.
                if (value == '0) begin
                    stateNext   = ERR;
                    errcodeNext = ERR_ZERO;
                end else if (value == DATAWIDTH_BUS'(1)) begin
                    stateNext = DONE;
                end else if (steps == STEPS_MAX) begin
                    stateNext   = ERR;
                    errcodeNext = ERR_STEPS;
                end else if (aluOverflow) begin
                    stateNext   = ERR;
                    errcodeNext = ERR_OVF;
                end else begin
                    valueNext = aluValue;
                    stepsNext = steps + STEPWIDTH'(1);
`ifdef COLLATZ_MAXTRACK_EN
                    if (aluValue > peak) peakNext = aluValue;
`endif
                end
            end
            default: begin
                if (collatzBus.start_In) begin
                    stateNext   = RUN;
                    errcodeNext = ERR_NONE;
                    valueNext   = collatzBus.seed_InBUS;
                    stepsNext   = '0;
`ifdef COLLATZ_MAXTRACK_EN
                    peakNext    = collatzBus.seed_InBUS;
`endif
                end
            end
        endcase
    end

    assign collatzBus.value_OutBUS   = value;
    assign collatzBus.steps_OutBUS   = steps;
    assign collatzBus.busy_Out       = (state == RUN);
    assign collatzBus.done_Out       = (state == DONE);
    assign collatzBus.err_Out        = (state == ERR);
    assign collatzBus.errcode_OutBUS = errcode;
`ifdef COLLATZ_MAXTRACK_EN
    assign collatzBus.peak_OutBUS    = peak;
`endif

endmodule
